video_timing_gen: RTL and testbench

Parametrised raster timing generator for the GPU display path, producing sync, data-enable, pixel position and frame-event strobes for any CEA/VESA-style mode. It generalises the fixed 1080p generator with:
- per-mode porch/sync parameters and sync polarity;
- a pixel clock-enable, so one system clock can drive lower pixel rates;
- registered outputs and a frame counter;
- an optional sync/DE delay line that aligns timing with the pixel-fetch pipeline latency.

It sits between the clock/reset block and the framebuffer scan-out / DAC interface.

---
 rtl/video_timing_gen_if.sv | 29 ++
 rtl/video_timing_gen.sv | 172 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: pixel-tick enable toward the generator, sync/DE/position/strobes back out.
`timescale 1ns/1ps
interface video_timing_gen_if #(
  parameter int XW = 12,
  parameter int YW = 11
);
  logic          i_ce;
  logic          o_hs;
  logic          o_vs;
  logic          o_de;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;
  logic          o_line_start;
  logic          o_frame_start;
  logic          o_animate;
  logic [15:0]   o_frame;

  modport master (
    input  i_ce,
    output o_hs, o_vs, o_de, o_x, o_y,
    output o_line_start, o_frame_start, o_animate, o_frame
  );

  modport slave (
    output i_ce,
    input  o_hs, o_vs, o_de, o_x, o_y,
    input  o_line_start, o_frame_start, o_animate, o_frame
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with pixel clock-enable and frame counter.
// Optional VTG_SYNC_DELAY_EN delays o_hs/o_vs/o_de by SYNC_DELAY enabled ticks.
`timescale 1ns/1ps
module video_timing_gen #(
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int XW         = 12,
  parameter int YW         = 11,
  parameter int SYNC_DELAY = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  video_timing_gen_if.master  vtg
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] H_ONE  = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0] H_ZERO = {XW{1'b0}};

  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_ANIM = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [YW-1:0] V_ONE  = {{(YW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] V_ZERO = {YW{1'b0}};

  logic [XW-1:0] h_r;
  logic [XW-1:0] h_nxt_s;
  logic [XW-1:0] x_r;
  logic [YW-1:0] v_r;
  logic [YW-1:0] v_nxt_s;
  logic [YW-1:0] y_r;
  logic          frame_wrap_s;
  logic          first_r;
  logic          hs_on_s;
  logic          vs_on_s;
  logic          de_on_s;
  logic          anim_on_s;
  logic          hs_r;
  logic          vs_r;
  logic          de_r;
  logic          ls_r;
  logic          fs_r;
  logic          anim_r;
  logic [15:0]   frame_r;

  // Position the next enabled tick will enter
  always_comb begin
    h_nxt_s      = h_r + H_ONE;
    v_nxt_s      = v_r;
    frame_wrap_s = 1'b0;
    if (h_r == H_LAST) begin
      h_nxt_s = H_ZERO;
      if (v_r == V_LAST) begin
        v_nxt_s      = V_ZERO;
        frame_wrap_s = 1'b1;
      end else begin
        v_nxt_s = v_r + V_ONE;
      end
    end else begin
      h_nxt_s = h_r + H_ONE;
    end
  end

  // Region decode of the upcoming position
  always_comb begin
    hs_on_s   = (h_nxt_s >= HS_BEG) && (h_nxt_s < HS_END);
    vs_on_s   = (v_nxt_s >= VS_BEG) && (v_nxt_s < VS_END);
    de_on_s   = (h_nxt_s < H_ACT) && (v_nxt_s < V_ACT);
    anim_on_s = (h_nxt_s == H_ACT) && (v_nxt_s == V_ANIM);
  end

  // Raster counters, registered outputs and frame counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // Park on the last position so the first enabled tick lands on (0,0)
      h_r     <= H_LAST;
      v_r     <= V_LAST;
      first_r <= 1'b1;
      x_r     <= H_ZERO;
      y_r     <= V_ZERO;
      hs_r    <= ~HS_POL;
      vs_r    <= ~VS_POL;
      de_r    <= 1'b0;
      ls_r    <= 1'b0;
      fs_r    <= 1'b0;
      anim_r  <= 1'b0;
      frame_r <= 16'h0000;
    end else if (vtg.i_ce) begin
      h_r     <= h_nxt_s;
      v_r     <= v_nxt_s;
      first_r <= 1'b0;
      x_r     <= h_nxt_s;
      y_r     <= v_nxt_s;
      hs_r    <= hs_on_s ? HS_POL : ~HS_POL;
      vs_r    <= vs_on_s ? VS_POL : ~VS_POL;
      de_r    <= de_on_s;
      ls_r    <= (h_nxt_s == H_ZERO);
      fs_r    <= (h_nxt_s == H_ZERO) && (v_nxt_s == V_ZERO);
      anim_r  <= anim_on_s;
      // The wrap out of reset is the first frame, not a new one
      if (frame_wrap_s && !first_r) begin
        frame_r <= frame_r + 16'd1;
      end else begin
        frame_r <= frame_r;
      end
    end else begin
      ls_r   <= 1'b0;
      fs_r   <= 1'b0;
      anim_r <= 1'b0;
    end
  end

`ifdef VTG_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_dly_r;
  logic [SYNC_DELAY-1:0] vs_dly_r;
  logic [SYNC_DELAY-1:0] de_dly_r;

  // Sync/DE delay line matching the pixel-fetch latency
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hs_dly_r <= {SYNC_DELAY{~HS_POL}};
      vs_dly_r <= {SYNC_DELAY{~VS_POL}};
      de_dly_r <= {SYNC_DELAY{1'b0}};
    end else if (vtg.i_ce) begin
      hs_dly_r[0] <= hs_r;
      vs_dly_r[0] <= vs_r;
      de_dly_r[0] <= de_r;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_dly_r[i] <= hs_dly_r[i-1];
        vs_dly_r[i] <= vs_dly_r[i-1];
        de_dly_r[i] <= de_dly_r[i-1];
      end
    end else begin
      hs_dly_r <= hs_dly_r;
      vs_dly_r <= vs_dly_r;
      de_dly_r <= de_dly_r;
    end
  end

  assign vtg.o_hs = hs_dly_r[SYNC_DELAY-1];
  assign vtg.o_vs = vs_dly_r[SYNC_DELAY-1];
  assign vtg.o_de = de_dly_r[SYNC_DELAY-1];
`else
  assign vtg.o_hs = hs_r;
  assign vtg.o_vs = vs_r;
  assign vtg.o_de = de_r;
`endif

  assign vtg.o_x           = x_r;
  assign vtg.o_y           = y_r;
  assign vtg.o_line_start  = ls_r;
  assign vtg.o_frame_start = fs_r;
  assign vtg.o_animate     = anim_r;
  assign vtg.o_frame       = frame_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen in a 16x8 mode: linear-index raster model plus directed checks.
`timescale 1ns/1ps
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int XW = 4, YW = 3, SD = 2;
`ifdef VTG_SYNC_DELAY_EN
  localparam int LAG = SD;
`else
  localparam int LAG = 0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  video_timing_gen_if #(.XW(XW), .YW(YW)) vif ();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .XW(XW), .YW(YW), .SYNC_DELAY(SD)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .vtg   (vif)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: linear pixel index within the frame
  int       m_idx;
  bit       m_started;
  bit       m_tick;
  bit [15:0] m_frame;
  bit       hist_hs [0:7];
  bit       hist_vs [0:7];
  bit       hist_de [0:7];

  function automatic bit a_hs(input int idx);
    int x = idx % HT;
    return (x >= HA + HF) && (x < HA + HF + HSW);
  endfunction
  function automatic bit a_vs(input int idx);
    int y = idx / HT;
    return (y >= VA + VF) && (y < VA + VF + VSW);
  endfunction
  function automatic bit a_de(input int idx);
    return ((idx % HT) < HA) && ((idx / HT) < VA);
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_started = 1'b0;
      m_idx     = 0;
      m_tick    = 1'b0;
      m_frame   = 16'h0000;
      for (int k = 0; k < 8; k++) begin
        hist_hs[k] = 1'b0;
        hist_vs[k] = 1'b0;
        hist_de[k] = 1'b0;
      end
    end else begin
      m_tick = vif.i_ce;
      if (vif.i_ce) begin
        if (!m_started) begin
          m_started = 1'b1;
          m_idx     = 0;
        end else begin
          m_idx = (m_idx + 1) % (HT * VT);
          if (m_idx == 0) m_frame = m_frame + 16'd1;
        end
        for (int k = 7; k > 0; k--) begin
          hist_hs[k] = hist_hs[k-1];
          hist_vs[k] = hist_vs[k-1];
          hist_de[k] = hist_de[k-1];
        end
        hist_hs[0] = a_hs(m_idx);
        hist_vs[0] = a_vs(m_idx);
        hist_de[0] = a_de(m_idx);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge i_clk) begin
    int ex, ey;
    ex = m_started ? (m_idx % HT) : 0;
    ey = m_started ? (m_idx / HT) : 0;
    chk("x",      32'(vif.o_x), 32'(ex));
    chk("y",      32'(vif.o_y), 32'(ey));
    chk("hs",     32'(vif.o_hs), 32'(hist_hs[LAG]));
    chk("vs",     32'(vif.o_vs), 32'(hist_vs[LAG]));
    chk("de",     32'(vif.o_de), 32'(hist_de[LAG]));
    chk("ls",     32'(vif.o_line_start),  32'(m_tick && m_started && ex == 0));
    chk("fs",     32'(vif.o_frame_start), 32'(m_tick && m_started && ex == 0 && ey == 0));
    chk("anim",   32'(vif.o_animate),     32'(m_tick && m_started && ex == HA && ey == VA - 1));
    chk("frame",  32'(vif.o_frame), 32'(m_frame));
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int ls_cnt, ls_last, hs_first, hs_cnt, de_first, vs_cnt, vs_first_y;
    int anim_cnt, anim_x, anim_y;
    bit found;

    vif.i_ce = 1'b0;
    i_rst    = 1'b1;
    wait_neg(3);
    chk("rst_hs", 32'(vif.o_hs), 32'd0);
    chk("rst_vs", 32'(vif.o_vs), 32'd0);
    chk("rst_de", 32'(vif.o_de), 32'd0);
    chk("rst_xy", 32'({vif.o_x, vif.o_y}), 32'd0);
    chk("rst_fs", 32'(vif.o_frame_start), 32'd0);

    // Scenarios 1-3: one full frame after reset release
    i_rst    = 1'b0;
    vif.i_ce = 1'b1;
    ls_cnt = 0; ls_last = 0; hs_first = -1; hs_cnt = 0; de_first = -1;
    vs_cnt = 0; vs_first_y = -1; anim_cnt = 0; anim_x = -1; anim_y = -1;
    for (int i = 0; i <= HT * VT; i++) begin
      wait_neg(1);
      if (i == 0) begin
        chk("first_x",  32'(vif.o_x), 32'd0);
        chk("first_y",  32'(vif.o_y), 32'd0);
        chk("first_de", 32'(vif.o_de), (LAG == 0) ? 32'd1 : 32'd0);
        chk("first_fs", 32'(vif.o_frame_start), 32'd1);
        chk("first_ls", 32'(vif.o_line_start), 32'd1);
        chk("first_frame", 32'(vif.o_frame), 32'd0);
      end else if (vif.o_line_start) begin
        ls_cnt++;
        chk("ls_period", 32'(i - ls_last), 32'd16);
        ls_last = i;
      end
      if (vif.o_hs && vif.o_y == 3'd0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(vif.o_x);
      end
      if (vif.o_de && de_first < 0) de_first = i;
      if (vif.o_vs) begin
        vs_cnt++;
        if (vs_first_y < 0) vs_first_y = int'(vif.o_y);
      end
      if (vif.o_animate) begin
        anim_cnt++;
        anim_x = int'(vif.o_x);
        anim_y = int'(vif.o_y);
      end
    end
    chk("ls_count",  32'(ls_cnt), 32'd8);
    chk("hs_first",  32'(hs_first), 32'(10 + LAG));
    chk("hs_width",  32'(hs_cnt), 32'd3);
    chk("de_first",  32'(de_first), 32'(LAG));
    chk("vs_count",  32'(vs_cnt), 32'd32);
    chk("vs_first_y", 32'(vs_first_y), 32'd5);
    chk("anim_count", 32'(anim_cnt), 32'd1);
    chk("anim_pos",  32'(anim_x * 16 + anim_y), 32'(8 * 16 + 3));
    chk("frame_one", 32'(vif.o_frame), 32'd1);

    // Frame counter wrap from a preloaded 0xFFFF
    @(posedge i_clk); #2;
    force dut.frame_r = 16'hFFFF;
    m_frame = 16'hFFFF;
    @(posedge i_clk); #2;
    release dut.frame_r;
    wait_neg(1);
    chk("frame_preload", 32'(vif.o_frame), 32'h0000_FFFF);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      wait_neg(1);
      if (vif.o_x == 4'd0 && vif.o_y == 3'd0) found = 1'b1;
    end
    chk("wrap_reached", 32'(found), 32'd1);
    chk("frame_wrap", 32'(vif.o_frame), 32'd0);

    // Scenario 4: i_ce pattern 1,0,0,1 around a line start
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      wait_neg(1);
      if (vif.o_x == 4'd14) found = 1'b1;
    end
    chk("ce_seek", 32'(found), 32'd1);
    wait_neg(1);
    chk("ce_x15", 32'(vif.o_x), 32'd15);
    wait_neg(1);
    chk("ce_x0",  32'(vif.o_x), 32'd0);
    chk("ce_ls1", 32'(vif.o_line_start), 32'd1);
    vif.i_ce = 1'b0;
    wait_neg(1);
    chk("ce_hold_x",  32'(vif.o_x), 32'd0);
    chk("ce_hold_ls", 32'(vif.o_line_start), 32'd0);
    wait_neg(1);
    chk("ce_hold_x2", 32'(vif.o_x), 32'd0);
    vif.i_ce = 1'b1;
    wait_neg(1);
    chk("ce_x1",  32'(vif.o_x), 32'd1);
    chk("ce_ls0", 32'(vif.o_line_start), 32'd0);

    // Scenario 5: asynchronous reset at (5,2) in frame 1
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      wait_neg(1);
      if (vif.o_x == 4'd5 && vif.o_y == 3'd2 && vif.o_frame == 16'd1) found = 1'b1;
    end
    chk("rst_seek", 32'(found), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("arst_x",     32'(vif.o_x), 32'd0);
    chk("arst_y",     32'(vif.o_y), 32'd0);
    chk("arst_de",    32'(vif.o_de), 32'd0);
    chk("arst_hs_vs", 32'({vif.o_hs, vif.o_vs}), 32'd0);
    chk("arst_frame", 32'(vif.o_frame), 32'd0);
    wait_neg(2);
    i_rst = 1'b0;
    wait_neg(1);
    chk("post_xy",    32'({vif.o_x, vif.o_y}), 32'd0);
    chk("post_fs",    32'(vif.o_frame_start), 32'd1);
    chk("post_frame", 32'(vif.o_frame), 32'd0);
    wait_neg(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
